// File: rtl/pep_ks_common_param_pkg.sv
// Shared key-switch parameters and command type, plus the result-command
// scheduler state encoding.
package pep_ks_common_param_pkg;

  localparam int unsigned LBX             = 3;
  localparam int unsigned KS_BLOCK_COL_NB = 8;
  localparam int unsigned KS_BLOCK_COL_W  = $clog2(KS_BLOCK_COL_NB);
  localparam int unsigned KS_LOOP_W       = 8;
  localparam int unsigned PID_W           = 4;

  typedef struct packed {
    logic [KS_LOOP_W-1:0] ks_loop;
    logic [PID_W-1:0]     wp;
    logic [PID_W-1:0]     rp;
  } ks_cmd_t;

  localparam int unsigned KS_CMD_W = $bits(ks_cmd_t);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    FLUSH
  } sched_state_e;

  function automatic logic [KS_LOOP_W-1:0] col_to_ks_loop(input logic [KS_BLOCK_COL_W-1:0] col);
    return KS_LOOP_W'(col) * KS_LOOP_W'(LBX);
  endfunction

endpackage

// File: rtl/fifo_reg.sv
// Small register-based FIFO with valid/ready on both sides and a synchronous
// clear that overrides any push or pop in its cycle.
module fifo_reg #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             a_rst,
  input  logic             clr,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_vld,
  output logic             in_rdy,
  output logic [WIDTH-1:0] out_data,
  output logic             out_vld,
  input  logic             out_rdy
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign in_rdy   = (cnt_q != CNT_W'(DEPTH));
  assign out_vld  = (cnt_q != '0);
  assign out_data = mem_q[rd_ptr_q];

  always_comb begin
    push     = in_vld & in_rdy & ~clr;
    pop      = out_vld & out_rdy & ~clr;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = in_data;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/pep_ks_res_cmd_sched.sv
// Expands per-batch (wp, rp) commands into per-column result commands under
// credit flow control. Define PEP_KS_RES_SCHED_STATS_EN for issue/stall counters.
module pep_ks_res_cmd_sched
  import pep_ks_common_param_pkg::*;
#(
  parameter int unsigned CREDIT_NB        = 4,
  parameter int unsigned BATCH_FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                a_rst,
  input  logic [KS_CMD_W-1:0] batch_cmd,
  input  logic                batch_cmd_vld,
  output logic                batch_cmd_rdy,
  output logic [KS_CMD_W-1:0] res_cmd,
  output logic                res_cmd_vld,
  input  logic                res_cmd_rdy,
  input  logic                res_col_done,
  input  logic                reset_cache,
  output logic                credit_err,
  output logic                busy
`ifdef PEP_KS_RES_SCHED_STATS_EN
  ,
  output logic [31:0]         stat_cmd_cnt,
  output logic [31:0]         stat_stall_cnt
`endif
);

  localparam int unsigned CREDIT_W = $clog2(CREDIT_NB + 1);
  localparam int unsigned FIFO_W   = 2 * PID_W;

  sched_state_e              state_q, state_d;
  logic [KS_BLOCK_COL_W-1:0] col_q, col_d;
  logic [CREDIT_W-1:0]       credit_q, credit_d;
  logic                      err_q, err_d;
  ks_cmd_t                   cmd_q, cmd_d;

  ks_cmd_t                   batch_in;
  ks_cmd_t                   load_cmd;
  logic [KS_LOOP_W-1:0]      unused_batch_ks_loop;
  logic [FIFO_W-1:0]         fifo_out_data;
  logic                      fifo_out_vld, fifo_in_rdy, fifo_pop, fifo_clr, fifo_in_vld;
  logic                      in_issue, cmd_hs, last_col, credit_full;

  assign batch_in             = batch_cmd;
  assign unused_batch_ks_loop = batch_in.ks_loop;

  // The FIFO is cleared in the reset_cache cycle as well, so any push accepted
  // alongside the flush request is discarded together with the queued batches.
  assign fifo_clr    = reset_cache | (state_q == FLUSH);
  assign fifo_in_vld = batch_cmd_vld & (state_q != FLUSH);

  fifo_reg #(
    .WIDTH (FIFO_W),
    .DEPTH (BATCH_FIFO_DEPTH)
  ) u_batch_fifo (
    .clk      (clk),
    .a_rst    (a_rst),
    .clr      (fifo_clr),
    .in_data  ({batch_in.wp, batch_in.rp}),
    .in_vld   (fifo_in_vld),
    .in_rdy   (fifo_in_rdy),
    .out_data (fifo_out_data),
    .out_vld  (fifo_out_vld),
    .out_rdy  (fifo_pop)
  );

  assign in_issue      = (state_q == ISSUE);
  assign res_cmd_vld   = in_issue & (credit_q != '0);
  assign cmd_hs        = res_cmd_vld & res_cmd_rdy & ~reset_cache;
  assign last_col      = (col_q == KS_BLOCK_COL_W'(KS_BLOCK_COL_NB - 1));
  assign credit_full   = (credit_q == CREDIT_W'(CREDIT_NB));
  assign batch_cmd_rdy = fifo_in_rdy & (state_q != FLUSH) & ~a_rst;
  assign res_cmd       = cmd_q;
  assign credit_err    = err_q;
  assign busy          = (state_q != IDLE) | ~credit_full | fifo_out_vld;

  always_comb begin
    load_cmd    = '0;
    load_cmd.wp = fifo_out_data[FIFO_W-1:PID_W];
    load_cmd.rp = fifo_out_data[PID_W-1:0];
  end

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    credit_d = credit_q;
    err_d    = err_q;
    cmd_d    = cmd_q;
    fifo_pop = 1'b0;
    if (reset_cache) begin
      state_d = FLUSH;
    end else begin
      case (state_q)
        IDLE: begin
          if (fifo_out_vld) begin
            fifo_pop = 1'b1;
            cmd_d    = load_cmd;
            col_d    = '0;
            state_d  = ISSUE;
          end
        end
        ISSUE: begin
          if (cmd_hs) begin
            if (!last_col) begin
              col_d         = col_q + 1'b1;
              cmd_d.ks_loop = col_to_ks_loop(col_q + 1'b1);
            end else if (fifo_out_vld) begin
              fifo_pop = 1'b1;
              cmd_d    = load_cmd;
              col_d    = '0;
            end else begin
              col_d   = '0;
              state_d = IDLE;
            end
          end
        end
        FLUSH: begin
          state_d  = IDLE;
          col_d    = '0;
          credit_d = CREDIT_W'(CREDIT_NB);
          cmd_d    = '0;
        end
        default: state_d = IDLE;
      endcase
      // A spurious return at full credit flags the error even when it
      // coincides with an issue; the counter itself then stays unchanged.
      if (state_q != FLUSH) begin
        if (res_col_done && credit_full) err_d = 1'b1;
        if (cmd_hs && !res_col_done) credit_d = credit_q - 1'b1;
        else if (!cmd_hs && res_col_done && !credit_full) credit_d = credit_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      state_q  <= IDLE;
      col_q    <= '0;
      credit_q <= CREDIT_W'(CREDIT_NB);
      err_q    <= 1'b0;
      cmd_q    <= '0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      credit_q <= credit_d;
      err_q    <= err_d;
      cmd_q    <= cmd_d;
    end
  end

`ifdef PEP_KS_RES_SCHED_STATS_EN
  logic [31:0] stat_cmd_q, stat_cmd_d, stat_stall_q, stat_stall_d;

  always_comb begin
    stat_cmd_d   = stat_cmd_q + 32'(cmd_hs);
    stat_stall_d = stat_stall_q + 32'(in_issue && (credit_q == '0));
  end

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      stat_cmd_q   <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_cmd_q   <= stat_cmd_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_cmd_cnt   = stat_cmd_q;
  assign stat_stall_cnt = stat_stall_q;
`endif

endmodule

// File: tb/tb_pep_ks_res_cmd_sched.sv
// Self-checking bench for pep_ks_res_cmd_sched: directed scenarios plus a
// randomized run scored against a queue-based command/credit model.
module tb_pep_ks_res_cmd_sched;
  import pep_ks_common_param_pkg::*;

  localparam int unsigned CREDIT_NB = 4;
  localparam int unsigned COLS      = KS_BLOCK_COL_NB;

  logic                clk;
  logic                a_rst;
  logic [KS_CMD_W-1:0] batch_cmd;
  logic                batch_cmd_vld;
  logic                batch_cmd_rdy;
  logic [KS_CMD_W-1:0] res_cmd;
  logic                res_cmd_vld;
  logic                res_cmd_rdy;
  logic                res_col_done;
  logic                reset_cache;
  logic                credit_err;
  logic                busy;
`ifdef PEP_KS_RES_SCHED_STATS_EN
  logic [31:0]         stat_cmd_cnt;
  logic [31:0]         stat_stall_cnt;
`endif

  pep_ks_res_cmd_sched #(
    .CREDIT_NB        (CREDIT_NB),
    .BATCH_FIFO_DEPTH (2)
  ) dut (
    .clk           (clk),
    .a_rst         (a_rst),
    .batch_cmd     (batch_cmd),
    .batch_cmd_vld (batch_cmd_vld),
    .batch_cmd_rdy (batch_cmd_rdy),
    .res_cmd       (res_cmd),
    .res_cmd_vld   (res_cmd_vld),
    .res_cmd_rdy   (res_cmd_rdy),
    .res_col_done  (res_col_done),
    .reset_cache   (reset_cache),
    .credit_err    (credit_err),
    .busy          (busy)
`ifdef PEP_KS_RES_SCHED_STATS_EN
    ,
    .stat_cmd_cnt   (stat_cmd_cnt),
    .stat_stall_cnt (stat_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: accepted-but-unissued commands, observed issues, credits in use.
  ks_cmd_t exp_q[$];
  ks_cmd_t obs_q[$];
  ks_cmd_t pair_q[$];
  int      obs_cyc_q[$];
  int      done_due[$];
  int      cyc = 0;
  int      outstanding = 0;
  int      cred_viol = 0;
  int      stab_viol = 0;
  bit      echo_en = 0;
  bit      prev_stall = 0;
  bit      in_flush = 0;
  ks_cmd_t prev_cmd;

  function automatic ks_cmd_t mk(input int col, input int wp, input int rp);
    ks_cmd_t m;
    m.ks_loop = KS_LOOP_W'(col * LBX);
    m.wp      = PID_W'(wp);
    m.rp      = PID_W'(rp);
    return m;
  endfunction

  task automatic clear_tracking();
    obs_q.delete(); pair_q.delete(); obs_cyc_q.delete(); done_due.delete();
    cred_viol = 0; stab_viol = 0;
  endtask

  // Advances one clock; inputs already driven for this cycle are what the DUT sees.
  task automatic cycle();
    bit      hs, bhs;
    ks_cmd_t bc, none;
    none = 'x;
    if (echo_en) begin
      res_col_done = (done_due.size() > 0) && (done_due[0] == cyc);
      if (res_col_done) void'(done_due.pop_front());
    end
    hs  = res_cmd_vld && res_cmd_rdy && !reset_cache;
    bhs = batch_cmd_vld && batch_cmd_rdy && !reset_cache;
    if (prev_stall && (!res_cmd_vld || res_cmd !== prev_cmd)) stab_viol++;
    if (res_cmd_vld && outstanding >= int'(CREDIT_NB)) cred_viol++;
    if (hs) begin
      obs_q.push_back(ks_cmd_t'(res_cmd));
      obs_cyc_q.push_back(cyc);
      pair_q.push_back(exp_q.size() > 0 ? exp_q.pop_front() : none);
      outstanding++;
      if (echo_en) done_due.push_back(cyc + 2);
    end
    if (res_col_done && !reset_cache && !in_flush && outstanding > 0) outstanding--;
    if (bhs) begin
      bc = ks_cmd_t'(batch_cmd);
      for (int c = 0; c < int'(COLS); c++) exp_q.push_back(mk(c, int'(bc.wp), int'(bc.rp)));
    end
    if (reset_cache) begin
      exp_q.delete(); done_due.delete(); outstanding = 0;
    end
    prev_stall = res_cmd_vld && !res_cmd_rdy && !reset_cache;
    prev_cmd   = res_cmd;
    in_flush   = reset_cache;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send_batch(input int wp, input int rp, output bit ok, output int acc_cyc);
    ks_cmd_t c;
    bit      took;
    c = '0; c.ks_loop = KS_LOOP_W'($urandom); c.wp = PID_W'(wp); c.rp = PID_W'(rp);
    batch_cmd = c; batch_cmd_vld = 1'b1; ok = 0; acc_cyc = -1;
    for (int n = 0; n < 50 && !ok; n++) begin
      took = batch_cmd_rdy && !reset_cache;
      acc_cyc = cyc;
      cycle();
      ok = took;
    end
    batch_cmd_vld = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 0;
    batch_cmd_vld = 1'b0; reset_cache = 1'b0; res_cmd_rdy = 1'b1;
    for (int n = 0; n < 400 && !ok; n++) begin
      if (!busy && exp_q.size() == 0 && !res_cmd_vld && outstanding == 0 && done_due.size() == 0) ok = 1;
      else begin
        if (!echo_en) res_col_done = (outstanding > 0);
        cycle();
      end
    end
    res_col_done = 1'b0;
  endtask

  task automatic test_reset();
    a_rst = 1'b1; batch_cmd = '0; batch_cmd_vld = 0; res_cmd_rdy = 0;
    res_col_done = 0; reset_cache = 0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (res_cmd_vld !== 1'b0) $display("FAIL rst_vld: got %b want 0", res_cmd_vld); else n_pass++;
    n_checks++; if (res_cmd !== '0) $display("FAIL rst_cmd: got %h want 0", res_cmd); else n_pass++;
    n_checks++; if (batch_cmd_rdy !== 1'b0) $display("FAIL rst_brdy: got %b want 0", batch_cmd_rdy); else n_pass++;
    n_checks++; if (credit_err !== 1'b0) $display("FAIL rst_err: got %b want 0", credit_err); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
    a_rst = 1'b0;
    #1;
    n_checks++; if (batch_cmd_rdy !== 1'b1) $display("FAIL post_rst_brdy: got %b want 1", batch_cmd_rdy); else n_pass++;
  endtask

  task automatic test_single_batch();
    bit ok; int acc;
    clear_tracking(); echo_en = 1; res_cmd_rdy = 1;
    send_batch(3, 1, ok, acc);
    n_checks++; if (!ok) $display("FAIL single_accept: got timeout want accepted"); else n_pass++;
    wait_idle(ok);
    n_checks++; if (!ok) $display("FAIL single_idle: got timeout want idle"); else n_pass++;
    n_checks++; if (obs_q.size() != COLS) $display("FAIL single_count: got %0d want %0d", obs_q.size(), COLS); else n_pass++;
    for (int i = 0; i < obs_q.size() && i < int'(COLS); i++) begin
      n_checks++;
      if (obs_q[i] !== mk(i, 3, 1)) $display("FAIL single_cmd[%0d]: got %h want %h", i, obs_q[i], mk(i, 3, 1));
      else n_pass++;
    end
    if (obs_cyc_q.size() > 0) begin
      n_checks++;
      if (obs_cyc_q[0] - acc != 2) $display("FAIL single_latency: got %0d want 2", obs_cyc_q[0] - acc);
      else n_pass++;
    end
    n_checks++; if (busy !== 1'b0) $display("FAIL single_busy: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_credit_limit();
    bit ok; int acc, d;
    clear_tracking(); echo_en = 0; res_cmd_rdy = 1; res_col_done = 0;
    send_batch(5, 2, ok, acc);
    n_checks++; if (!ok) $display("FAIL credit_accept: got timeout want accepted"); else n_pass++;
    repeat (12) cycle();
    n_checks++; if (obs_q.size() != CREDIT_NB) $display("FAIL credit_cap: got %0d want %0d", obs_q.size(), CREDIT_NB); else n_pass++;
    n_checks++; if (res_cmd_vld !== 1'b0) $display("FAIL credit_vld_low: got %b want 0", res_cmd_vld); else n_pass++;
    res_col_done = 1; d = cyc; cycle(); res_col_done = 0;
    repeat (4) cycle();
    n_checks++; if (obs_q.size() != CREDIT_NB + 1) $display("FAIL credit_one_more: got %0d want %0d", obs_q.size(), CREDIT_NB + 1); else n_pass++;
    if (obs_cyc_q.size() > int'(CREDIT_NB)) begin
      n_checks++;
      if (obs_cyc_q[CREDIT_NB] != d + 1) $display("FAIL credit_return_lat: got %0d want %0d", obs_cyc_q[CREDIT_NB], d + 1);
      else n_pass++;
    end
    wait_idle(ok);
    n_checks++; if (!ok) $display("FAIL credit_drain: got timeout want idle"); else n_pass++;
    n_checks++; if (obs_q.size() != COLS) $display("FAIL credit_total: got %0d want %0d", obs_q.size(), COLS); else n_pass++;
    n_checks++; if (cred_viol != 0) $display("FAIL credit_overissue: got %0d want 0", cred_viol); else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit ok; int acc;
    clear_tracking(); echo_en = 1; res_cmd_rdy = 1;
    send_batch(1, 2, ok, acc);
    send_batch(4, 6, ok, acc);
    n_checks++; if (!ok) $display("FAIL b2b_accept: got timeout want accepted"); else n_pass++;
    wait_idle(ok);
    n_checks++; if (obs_q.size() != 2 * COLS) $display("FAIL b2b_count: got %0d want %0d", obs_q.size(), 2 * COLS); else n_pass++;
    if (obs_q.size() == 2 * COLS) begin
      n_checks++; if (obs_q[COLS-1] !== mk(COLS - 1, 1, 2)) $display("FAIL b2b_lastA: got %h want %h", obs_q[COLS-1], mk(COLS - 1, 1, 2)); else n_pass++;
      n_checks++; if (obs_q[COLS] !== mk(0, 4, 6)) $display("FAIL b2b_firstB: got %h want %h", obs_q[COLS], mk(0, 4, 6)); else n_pass++;
      n_checks++; if (obs_cyc_q[COLS] - obs_cyc_q[COLS-1] != 1) $display("FAIL b2b_bubble: got gap %0d want 1", obs_cyc_q[COLS] - obs_cyc_q[COLS-1]); else n_pass++;
      n_checks++; if (obs_cyc_q[2*COLS-1] - obs_cyc_q[0] != 2 * COLS - 1) $display("FAIL b2b_span: got %0d want %0d", obs_cyc_q[2*COLS-1] - obs_cyc_q[0], 2 * COLS - 1); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    bit ok; int acc;
    clear_tracking(); echo_en = 1; res_cmd_rdy = 1;
    send_batch(7, 3, ok, acc);
    for (int n = 0; n < 20 && obs_q.size() < 2; n++) cycle();
    n_checks++; if (obs_q.size() != 2) $display("FAIL bp_reach_col2: got %0d want 2", obs_q.size()); else n_pass++;
    res_cmd_rdy = 0;
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (res_cmd_vld !== 1'b1 || res_cmd !== mk(2, 7, 3)) $display("FAIL bp_hold[%0d]: got vld=%b cmd=%h want vld=1 cmd=%h", k, res_cmd_vld, res_cmd, mk(2, 7, 3));
      else n_pass++;
      cycle();
    end
    res_cmd_rdy = 1;
    cycle();
    n_checks++; if (obs_q.size() != 3 || obs_q[obs_q.size()-1] !== mk(2, 7, 3)) $display("FAIL bp_release: got n=%0d want n=3 col2", obs_q.size()); else n_pass++;
    wait_idle(ok);
    n_checks++; if (obs_q.size() != COLS) $display("FAIL bp_total: got %0d want %0d", obs_q.size(), COLS); else n_pass++;
    n_checks++; if (obs_q.size() > 3 && obs_q[3] !== mk(3, 7, 3)) $display("FAIL bp_col3: got %h want %h", obs_q[3], mk(3, 7, 3)); else n_pass++;
  endtask

  task automatic test_flush();
    bit ok; int acc;
    clear_tracking(); echo_en = 0; res_cmd_rdy = 1; res_col_done = 0;
    send_batch(9, 5, ok, acc);
    send_batch(8, 8, ok, acc);
    for (int n = 0; n < 20 && obs_q.size() < 3; n++) cycle();
    res_cmd_rdy = 0; res_col_done = 1; cycle(); res_col_done = 0;
    n_checks++; if (res_cmd !== mk(3, 9, 5)) $display("FAIL flush_at_col3: got %h want %h", res_cmd, mk(3, 9, 5)); else n_pass++;
    reset_cache = 1; res_cmd_rdy = 1; cycle(); reset_cache = 0;
    n_checks++; if (res_cmd_vld !== 1'b0) $display("FAIL flush_vld: got %b want 0", res_cmd_vld); else n_pass++;
    n_checks++; if (batch_cmd_rdy !== 1'b0) $display("FAIL flush_brdy: got %b want 0", batch_cmd_rdy); else n_pass++;
    cycle();
    n_checks++; if (busy !== 1'b0) $display("FAIL flush_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (batch_cmd_rdy !== 1'b1) $display("FAIL flush_brdy_after: got %b want 1", batch_cmd_rdy); else n_pass++;
    repeat (5) cycle();
    n_checks++; if (obs_q.size() != 3) $display("FAIL flush_no_issue: got %0d want 3", obs_q.size()); else n_pass++;
    echo_en = 1;
    send_batch(2, 2, ok, acc);
    wait_idle(ok);
    n_checks++; if (obs_q.size() != 3 + COLS) $display("FAIL flush_restart_count: got %0d want %0d", obs_q.size(), 3 + COLS); else n_pass++;
    n_checks++; if (obs_q.size() > 3 && obs_q[3] !== mk(0, 2, 2)) $display("FAIL flush_restart: got %h want %h", obs_q[3], mk(0, 2, 2)); else n_pass++;
  endtask

  task automatic test_credit_err();
    bit ok; int acc;
    clear_tracking(); echo_en = 0; res_cmd_rdy = 1;
    res_col_done = 1; cycle(); res_col_done = 0;
    n_checks++; if (credit_err !== 1'b1) $display("FAIL err_set: got %b want 1", credit_err); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL err_credit_sat: got busy=%b want 0", busy); else n_pass++;
    send_batch(6, 1, ok, acc);
    repeat (12) cycle();
    n_checks++; if (obs_q.size() != CREDIT_NB) $display("FAIL err_cap: got %0d want %0d", obs_q.size(), CREDIT_NB); else n_pass++;
    wait_idle(ok);
    reset_cache = 1; cycle(); reset_cache = 0; cycle(); cycle();
    n_checks++; if (credit_err !== 1'b1) $display("FAIL err_sticky: got %b want 1", credit_err); else n_pass++;
    a_rst = 1; #1;
    n_checks++; if (credit_err !== 1'b0) $display("FAIL err_arst: got %b want 0", credit_err); else n_pass++;
    @(posedge clk); #1; a_rst = 0;
  endtask

  task automatic test_random();
    bit ok;
    ks_cmd_t r;
    clear_tracking(); echo_en = 0;
    for (int n = 0; n < 1500; n++) begin
      r = ks_cmd_t'(KS_CMD_W'($urandom));
      batch_cmd     = r;
      batch_cmd_vld = ($urandom_range(0, 9) < 3);
      res_cmd_rdy   = ($urandom_range(0, 9) < 7);
      res_col_done  = (outstanding > 0) && ($urandom_range(0, 1) == 1);
      reset_cache   = ($urandom_range(0, 199) == 0);
      cycle();
    end
    reset_cache = 0;
    wait_idle(ok);
    n_checks++; if (!ok) $display("FAIL rnd_drain: got timeout want idle"); else n_pass++;
    for (int i = 0; i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== pair_q[i]) $display("FAIL rnd_cmd[%0d]: got %h want %h", i, obs_q[i], pair_q[i]);
      else n_pass++;
    end
    n_checks++; if (obs_q.size() < 50) $display("FAIL rnd_activity: got %0d issues want >=50", obs_q.size()); else n_pass++;
    n_checks++; if (cred_viol != 0) $display("FAIL rnd_credit: got %0d violations want 0", cred_viol); else n_pass++;
    n_checks++; if (stab_viol != 0) $display("FAIL rnd_stable: got %0d violations want 0", stab_viol); else n_pass++;
    n_checks++; if (credit_err !== 1'b0) $display("FAIL rnd_err: got %b want 0", credit_err); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_batch();
    test_credit_limit();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_random();
    test_credit_err();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pep_ks_res_cmd_sched.md
Name: pep_ks_res_cmd_sched

Overview:
Sequences the key-switch result formatter. It accepts one batch command (wp, rp) per BLWE batch from ks_control and expands it into KS_BLOCK_COL_NB per-column result commands, with ks_loop = col*LBX. Issue is throttled by a credit counter that mirrors the formatter's command/result buffering. A reset_cache pulse flushes the batch in flight.

Parameters:
CREDIT_NB, 4, max outstanding column commands not yet acknowledged by res_col_done; must be >=1.
BATCH_FIFO_DEPTH, 2, depth of the input batch-command FIFO; must be >=1.

Ports:
clk  in  1  clock
a_rst  in  1  asynchronous reset, active-high
batch_cmd  in  KS_CMD_W  ks_cmd_t; only wp and rp are used, ks_loop is ignored
batch_cmd_vld  in  1  batch command valid
batch_cmd_rdy  out  1  batch FIFO not full and not flushing
res_cmd  out  KS_CMD_W  ks_cmd_t {ks_loop=col*LBX, wp, rp}
res_cmd_vld  out  1  column command valid
res_cmd_rdy  in  1  formatter accepts the command
res_col_done  in  1  one-cycle pulse per column fully emitted by the formatter; returns one credit
reset_cache  in  1  one-cycle flush request
credit_err  out  1  sticky: credit returned while the counter was already at CREDIT_NB
busy  out  1  batch in flight, or credits outstanding

Behaviour:
- Reset values (async, while a_rst=1): state=IDLE, col=0, credit=CREDIT_NB, batch FIFO empty; res_cmd_vld=0, res_cmd=0, batch_cmd_rdy=0, credit_err=0, busy=0.
- Batch FIFO uses a valid/ready handshake. batch_cmd_rdy = ~full & (state!=FLUSH).
- FSM states: IDLE, ISSUE, FLUSH.
  - IDLE: if the FIFO is non-empty, pop it, latch wp/rp, set col=0, and go to ISSUE next cycle.
  - ISSUE: res_cmd_vld = (credit>0), driven combinationally from registered state. res_cmd is registered.
    - On res_cmd_vld & res_cmd_rdy: credit decrements.
    - If col != KS_BLOCK_COL_NB-1: col increments.
    - Otherwise, on the last column: if the FIFO is non-empty, pop it and reload wp/rp with col=0, staying in ISSUE (zero-bubble back-to-back batches). If it is empty, go to IDLE.
  - FLUSH: entered from any state on reset_cache. Lasts exactly one cycle. Clears col, restores credit=CREDIT_NB, empties the batch FIFO, forces res_cmd_vld=0. Then returns to IDLE. credit_err is not cleared.
- Latency: 1 cycle from batch pop to res_cmd_vld=1, given credit>0.
- Credit arithmetic is on $clog2(CREDIT_NB+1) bits.
  - Issue and res_col_done in the same cycle: net change 0.
  - res_col_done at credit==CREDIT_NB: saturate at CREDIT_NB and set credit_err.
  - res_col_done during or in the cycle of FLUSH: ignored.
- reset_cache takes priority over every handshake in its cycle. A res_cmd handshake in that cycle is discarded: no credit or col update.
- res_cmd stays stable while res_cmd_vld=1 and res_cmd_rdy=0 (AXI-style stability rule).
- busy = (state!=IDLE) | (credit!=CREDIT_NB) | FIFO non-empty.

Optional Feature:
PEP_KS_RES_SCHED_STATS_EN
- Defined: adds outputs stat_cmd_cnt[31:0] (issued column commands) and stat_stall_cnt[31:0] (cycles in ISSUE with credit==0). Both wrap modulo 2^32, are cleared by a_rst only, and are unaffected by reset_cache.
- Undefined: these ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- pep_ks_common_param_pkg already provides ks_cmd_t, KS_CMD_W, KS_BLOCK_COL_NB, KS_BLOCK_COL_W and LBX; reuse them.
- Add to that package: sched_state_e {IDLE, ISSUE, FLUSH}.
- CREDIT_W = $clog2(CREDIT_NB+1) stays a local parameter.
- The batch FIFO is a sub-module instance of fifo_reg. Everything else stays flat.

Test Plan:
- Single batch, wp=3, rp=1, res_cmd_rdy=1, res_col_done echoed 2 cycles after each issue -> KS_BLOCK_COL_NB commands with ks_loop=0, LBX, 2*LBX, …, all carrying wp=3, rp=1. Idle afterwards, busy=0.
- CREDIT_NB=4, res_col_done held low -> exactly 4 commands issued, res_cmd_vld=0 thereafter. One res_col_done pulse -> exactly one more command the next cycle.
- Two batches queued back-to-back -> the last column of batch A is immediately followed by column 0 of batch B with no bubble cycle.
- res_cmd_rdy=0 for 5 cycles on column 2 -> res_cmd holds ks_loop=2*LBX unchanged, and col does not advance.
- reset_cache mid-batch at col=3 with 2 credits outstanding -> one FLUSH cycle, then credit=CREDIT_NB, FIFO empty, res_cmd_vld=0. A new batch restarts at ks_loop=0.
- Extra res_col_done at credit=CREDIT_NB -> credit_err=1 and stays high, credit remains CREDIT_NB. a_rst clears credit_err.
